// File: rtl/if_layer_scheduler.sv
// Time-multiplexed integrate-and-fire layer: one shared accumulator walks every neuron
// per timestep, fetching the weights of active inputs from an external weight memory.
module if_layer_scheduler #(
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_NEURONS = 8,
    parameter int WEIGHT_W    = 8,
    parameter int POT_W       = 16,
    parameter int THRESHOLD   = 10,
    parameter int RESET_POT   = 0,
    parameter int ADDR_W      = $clog2(NUM_NEURONS*NUM_INPUTS),
    localparam int NW         = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    localparam int IW         = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_INPUTS-1:0]  spike_in,
    input  logic                   clear_pot,
    output logic                   weight_rd,
    output logic [ADDR_W-1:0]      weight_addr,
    input  logic [WEIGHT_W-1:0]    weight_data,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_NEURONS-1:0] spike_out,
    input  logic [NW-1:0]          pot_idx,
    output logic [POT_W-1:0]       pot_data
);

    localparam int SW = ((POT_W > WEIGHT_W) ? POT_W : WEIGHT_W) + 1;
    localparam logic [POT_W-1:0] RST_P = POT_W'(RESET_POT);
    localparam int unsigned THR = THRESHOLD;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_LAST, S_UPDATE, S_DONE} state_t;

    state_t                 state;
    logic [NUM_INPUTS-1:0]  frame_q;
    logic [NW-1:0]          n;
    logic [IW-1:0]          i;
    logic [NUM_NEURONS-1:0] spk_q;
    logic                   rd_q;
    logic [POT_W-1:0]       acc;
    logic [POT_W-1:0]       pot [NUM_NEURONS];
    logic [SW-1:0]          sum;
    logic [POT_W-1:0]       acc_sat;
    logic                   fire;

    // Sum is widened by one bit so an overflow clamps instead of wrapping.
    always_comb begin
        sum     = SW'(acc) + SW'(weight_data);
        acc_sat = (sum > SW'({POT_W{1'b1}})) ? {POT_W{1'b1}} : sum[POT_W-1:0];
        fire    = 32'(acc) >= THR;
    end

    assign pot_data = pot[pot_idx];

    function automatic logic [ADDR_W-1:0] addr_of(input int nn, input int ii);
        return ADDR_W'(nn * NUM_INPUTS + ii);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            frame_q     <= '0;
            n           <= '0;
            i           <= '0;
            spk_q       <= '0;
            rd_q        <= 1'b0;
            acc         <= '0;
            weight_rd   <= 1'b0;
            weight_addr <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            spike_out   <= '0;
            for (int k = 0; k < NUM_NEURONS; k++) pot[k] <= RST_P;
        end else begin
            done <= 1'b0;
            rd_q <= weight_rd;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        frame_q     <= spike_in;
                        n           <= '0;
                        i           <= '0;
                        spk_q       <= '0;
                        busy        <= 1'b1;
                        weight_rd   <= spike_in[0];
                        weight_addr <= '0;
                        state       <= S_READ;
                    end else if (clear_pot) begin
                        for (int k = 0; k < NUM_NEURONS; k++) pot[k] <= RST_P;
                    end
                end
                S_READ: begin
                    // Data lands one cycle after its strobe, so the first READ cycle only seeds acc.
                    if (i == '0) acc <= pot[n];
                    else if (rd_q) acc <= acc_sat;
                    if (i == IW'(NUM_INPUTS-1)) begin
                        weight_rd <= 1'b0;
                        state     <= S_LAST;
                    end else begin
                        i           <= i + IW'(1);
                        weight_rd   <= frame_q[i + IW'(1)];
                        weight_addr <= addr_of(int'(n), int'(i) + 1);
                    end
                end
                S_LAST: begin
                    if (rd_q) acc <= acc_sat;
                    state <= S_UPDATE;
                end
                S_UPDATE: begin
                    pot[n]   <= fire ? RST_P : acc;
                    spk_q[n] <= fire;
                    if (n == NW'(NUM_NEURONS-1)) begin
                        state <= S_DONE;
                    end else begin
                        n           <= n + NW'(1);
                        i           <= '0;
                        weight_rd   <= frame_q[0];
                        weight_addr <= addr_of(int'(n) + 1, 0);
                        state       <= S_READ;
                    end
                end
                S_DONE: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    spike_out <= spk_q;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_layer_scheduler.sv
// Randomized bench for if_layer_scheduler against a per-neuron arithmetic reference model,
// plus a narrow-potential instance exercising saturation.
module tb_if_layer_scheduler;
    localparam int NI  = 4;
    localparam int NN  = 8;
    localparam int THR = 10;
    localparam int PMAX = 65535;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, clear_pot, weight_rd, busy, done;
    logic [3:0] spike_in;
    logic [4:0] weight_addr;
    logic [7:0] weight_data, spike_out;
    logic [2:0] pot_idx;
    logic [15:0] pot_data;

    logic       sat_start, sat_rd, sat_busy, sat_done;
    logic [3:0] sat_spike, sat_pot;
    logic [4:0] sat_addr;
    logic [7:0] sat_wdata, sat_spk_out;
    logic [2:0] sat_idx;

    int tests = 0;
    int fails = 0;
    int mem [32];
    int pot_m [NN];
    logic [7:0] spk_m;
    int rd_log [$];

    if_layer_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .spike_in(spike_in), .clear_pot(clear_pot),
        .weight_rd(weight_rd), .weight_addr(weight_addr), .weight_data(weight_data),
        .busy(busy), .done(done), .spike_out(spike_out), .pot_idx(pot_idx), .pot_data(pot_data)
    );

    if_layer_scheduler #(.POT_W(4), .THRESHOLD(16)) sat_dut (
        .clk(clk), .rst_n(rst_n), .start(sat_start), .spike_in(sat_spike), .clear_pot(1'b0),
        .weight_rd(sat_rd), .weight_addr(sat_addr), .weight_data(sat_wdata),
        .busy(sat_busy), .done(sat_done), .spike_out(sat_spk_out), .pot_idx(sat_idx), .pot_data(sat_pot)
    );

    // Weight memories answer one cycle after the strobe; garbage otherwise.
    always @(posedge clk) begin
        if (weight_rd) begin
            rd_log.push_back(int'(weight_addr));
            weight_data <= 8'(mem[weight_addr]);
        end else begin
            weight_data <= 8'($urandom);
        end
    end

    always @(posedge clk) sat_wdata <= sat_rd ? 8'd15 : 8'($urandom);

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic modelStep(input logic [3:0] fr);
        int acc;
        spk_m = '0;
        for (int nn = 0; nn < NN; nn++) begin
            acc = pot_m[nn];
            for (int ii = 0; ii < NI; ii++)
                if (fr[ii]) begin
                    acc = acc + mem[nn*NI + ii];
                    if (acc > PMAX) acc = PMAX;
                end
            if (acc >= THR) begin
                pot_m[nn]  = 0;
                spk_m[nn]  = 1'b1;
            end else begin
                pot_m[nn]  = acc;
            end
        end
    endtask

    task automatic checkPots(input string tag);
        for (int k = 0; k < NN; k++) begin
            pot_idx = 3'(k);
            #1;
            checkOutput($sformatf("%s pot[%0d]", tag, k), 32'(pot_data), 32'(pot_m[k]));
        end
    endtask

    task automatic applyStimulus(input logic [3:0] fr, input bit clr, input bit extra_start);
        int exp_addr [$];
        int lat;
        int ndone;
        for (int nn = 0; nn < NN; nn++)
            for (int ii = 0; ii < NI; ii++)
                if (fr[ii]) exp_addr.push_back(nn*NI + ii);
        @(negedge clk);
        rd_log.delete();
        start = 1'b1; spike_in = fr; clear_pot = clr;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; clear_pot = 1'b0; spike_in = 4'($urandom);
        checkOutput("busy_after_start", 32'(busy), 1);
        lat = 0; ndone = 0;
        for (int c = 1; c <= 62; c++) begin
            start = (extra_start && c == 9) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (done) begin
                ndone++;
                if (lat == 0) lat = c;
            end
            if (c == 48) checkOutput("busy_in_done", 32'(busy), 1);
            if (c == 49) checkOutput("busy_cleared", 32'(busy), 0);
        end
        modelStep(fr);
        checkOutput("latency", 32'(lat), 49);
        checkOutput("done_count", 32'(ndone), 1);
        checkOutput("spike_out", 32'(spike_out), 32'(spk_m));
        checkOutput("read_count", 32'(rd_log.size()), 32'(exp_addr.size()));
        if (rd_log.size() == exp_addr.size())
            foreach (exp_addr[k]) checkOutput($sformatf("addr#%0d", k), 32'(rd_log[k]), 32'(exp_addr[k]));
        checkPots("step");
    endtask

    initial begin
        int ndone;
        int sacc;
        start = 0; clear_pot = 0; spike_in = 0; pot_idx = 0;
        sat_start = 0; sat_spike = 0; sat_idx = 0;
        for (int k = 0; k < 32; k++) mem[k] = 0;
        for (int k = 0; k < NN; k++) pot_m[k] = 0;
        spk_m = '0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst busy", 32'(busy), 0);
        checkOutput("rst done", 32'(done), 0);
        checkOutput("rst spike_out", 32'(spike_out), 0);
        checkOutput("rst weight_rd", 32'(weight_rd), 0);
        checkOutput("rst weight_addr", 32'(weight_addr), 0);
        checkPots("rst");
        rst_n = 1'b1;

        mem[0] = 3; mem[1] = 4; mem[2] = 5; mem[3] = 6;
        applyStimulus(4'b0011, 0, 0);
        checkOutput("ts1 pot0", 32'(pot_m[0]), 7);
        applyStimulus(4'b0011, 0, 0);
        checkOutput("ts2 spikes", 32'(spk_m), 32'h01);
        applyStimulus(4'b0000, 0, 0);
        applyStimulus(4'b1111, 0, 1);

        for (int k = 0; k < 32; k++) mem[k] = $urandom_range(0, 6);
        applyStimulus(4'b0101, 0, 0);
        @(negedge clk); clear_pot = 1'b1;
        @(negedge clk); clear_pot = 1'b0;
        for (int k = 0; k < NN; k++) pot_m[k] = 0;
        checkPots("clear");
        checkOutput("clear keeps spike_out", 32'(spike_out), 32'(spk_m));
        applyStimulus(4'b0110, 0, 0);
        applyStimulus(4'b1011, 1, 0);

        for (int t = 0; t < 16; t++) begin
            if (t == 8) for (int k = 0; k < 32; k++) mem[k] = $urandom_range(0, 12);
            applyStimulus(4'($urandom), 1'($urandom), 1'($urandom));
        end

        // Abort a timestep with an asynchronous reset mid-flight.
        @(negedge clk); start = 1'b1; spike_in = 4'hF;
        @(negedge clk); start = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort busy", 32'(busy), 0);
        checkOutput("abort spike_out", 32'(spike_out), 0);
        checkOutput("abort weight_rd", 32'(weight_rd), 0);
        for (int k = 0; k < NN; k++) pot_m[k] = 0;
        spk_m = '0;
        ndone = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checkOutput("abort no done", 32'(ndone), 0);
        checkPots("abort");
        applyStimulus(4'b1101, 0, 0);

        // Narrow potentials: four weights of 15 must clamp at 15, never wrap.
        sacc = 0;
        for (int ts = 0; ts < 2; ts++) begin
            @(negedge clk); sat_start = 1'b1; sat_spike = 4'hF;
            @(negedge clk); sat_start = 1'b0;
            ndone = 0;
            for (int c = 0; c < 80 && ndone == 0; c++) begin
                @(negedge clk);
                if (sat_done) ndone = 1;
            end
            checkOutput("sat done seen", 32'(ndone), 1);
            for (int ii = 0; ii < NI; ii++) sacc = (sacc + 15 > 15) ? 15 : sacc + 15;
            if (sacc >= 16) sacc = 0;
            checkOutput("sat spike_out", 32'(sat_spk_out), 0);
            for (int k = 0; k < NN; k++) begin
                sat_idx = 3'(k);
                #1;
                checkOutput($sformatf("sat pot[%0d]", k), 32'(sat_pot), 32'(sacc));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
